mem_wb_stage: RTL
=================

# mem_wb_stage

Pipeline register and writeback formatter between the data-memory stage and the register file write port. Captures the memory-stage result each cycle, aligns and sign/zero-extends load data, selects ALU vs. memory result, and drives the register file's `we3`/`wa3`/`wd3` inputs. It also handles stall/flush, flags misaligned loads and counts retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low. One clock; asynchronous active-low reset.
- `m_valid`  in  1: the memory stage holds a real instruction.
- `m_regwrite`  in  1: the instruction writes a GPR.
- `m_memtoreg`  in  1: 1 selects load data, 0 selects ALU result.
- `m_ldtype`  in  3: load type, `LT_W`/`LT_B`/`LT_BU`/`LT_H`/`LT_HU`.
- `m_addr_lo`  in  2: byte address bits [1:0] of the load.
- `m_wa`  in  5: destination register.
- `m_aluout`  in  32: ALU result.
- `m_rdata`  in  32: raw little-endian word read from data memory.
- `stall_w`  in  1: hold the stage.
- `flush_w`  in  1: insert a bubble.
- `we3`  out  1: register file write enable.
- `wa3`  out  5: write address.
- `wd3`  out  32: write data.
- `w_adel`  out  1: one-cycle pulse flagging a misaligned load.
- `w_badaddr_lo`  out  2: offending address bits, valid with `w_adel`.
- `retired`  out  RETIRE_W: count of instructions entering writeback.

## Operation
- All outputs are registered. On reset (`rst_n`=0): every output is 0, including `retired`.
- **Load path**, when `m_memtoreg`=1:
  - `LT_W`: the whole word.
  - `LT_B`/`LT_BU`: byte `m_rdata[8*addr_lo +: 8]`, sign-extended / zero-extended.
  - `LT_H`/`LT_HU`: halfword `m_rdata[16*addr_lo[1] +: 16]`, sign-extended / zero-extended.
  - Undefined `m_ldtype` codes are treated as `LT_W`.
- **Misalignment:**
  - Misaligned means `LT_W` with `addr_lo`≠0, or H/HU with `addr_lo[0]`=1.
  - Applies only when `m_valid & m_memtoreg`.
- **Load cycle** (`stall_w`=0, `flush_w`=0), registers load:
  - `we3` = `m_valid & m_regwrite & (m_wa≠0) & ~misaligned`.
  - `wa3` = `m_wa`.
  - `wd3` = formatted data, or `m_aluout` when `m_memtoreg`=0.
  - `w_adel` = `m_valid & misaligned`; `w_badaddr_lo` = `m_addr_lo`.
  - `retired` increments by 1 iff `m_valid` and not misaligned.
- **Writes to register 0 are suppressed** (`we3`=0). The register file forwards `wd3` on an address match without checking for register 0, so `we3` must never be asserted with `wa3`=0.
- **Stall** (`stall_w`=1, `flush_w`=0):
  - `we3`/`wa3`/`wd3` hold. Re-writing the same value is idempotent.
  - `w_adel` goes to 0, so the pulse is never repeated.
  - `retired` holds.
- **Flush** (`flush_w`=1) takes priority over stall:
  - `we3`=0, `w_adel`=0, `retired` holds.
  - `wa3` and `wd3` are cleared to 0.
- `retired` wraps modulo 2^RETIRE_W.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on `we3`/`wa3`/`wd3` after edge N. The register file writes at edge N+1 and forwards combinationally during cycle N..N+1.
- No combinational path from any input to any output.
- Reset asserted mid-operation clears outputs immediately (asynchronous). The first load occurs on the first rising edge after `rst_n` deasserts.
- Simultaneous `stall_w` and `flush_w`: flush behaviour.
- Back-to-back valid instructions: one accepted per cycle, no bubbles.

## Structure
- Shared package `mips_wb_pkg`: `LT_W`=3'd0, `LT_B`=3'd1, `LT_BU`=3'd2, `LT_H`=3'd3, `LT_HU`=3'd4, and a `ldtype_t` typedef. The decoder uses the same package.
- Sub-module `load_align`, purely combinational:
  - Inputs: `rdata`, `addr_lo`, `ldtype`.
  - Outputs: formatted 32-bit data and `misaligned`.
  - Instantiated once; unit-testable in isolation.

## Test plan
- **Load-byte variants:** `m_rdata`=32'h80FF_7F01, `LT_B`, `addr_lo`=2 → `wd3`=32'hFFFF_FFFF; `LT_BU`, `addr_lo`=3 → 32'h0000_0080; `LT_B`, `addr_lo`=1 → 32'h0000_007F.
- **Halfword and misaligned word:**
  - `LT_H`, `addr_lo`=2, `m_rdata`=32'h8001_1234 → `wd3`=32'hFFFF_8001.
  - `LT_W`, `addr_lo`=1 → `we3`=0, `w_adel`=1 for exactly one cycle, `w_badaddr_lo`=1, `retired` unchanged.
- **Register 0 suppression:** ALU op with `m_wa`=0, `m_aluout`=32'hDEAD_BEEF, `m_regwrite`=1 → `we3`=0; `retired` increments.
- **Stall then flush:** valid write to r5=32'h1234 → 3 cycles of `stall_w` → `we3`/`wa3`/`wd3` held, `retired` +1 only once; then `stall_w`=`flush_w`=1 → `we3`=0, `wa3`=0, `wd3`=0.
- **Reset mid-stream:** assert `rst_n`=0 asynchronously between edges while `we3`=1 → all outputs 0 before the next edge; `retired`=0.
- **Counter wrap:** RETIRE_W=4, 17 consecutive valid instructions → `retired`=1.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared load-type encoding and extension helpers for the writeback path.
package mips_wb_pkg;

  typedef enum logic [2:0] {
    LT_W  = 3'd0,
    LT_B  = 3'd1,
    LT_BU = 3'd2,
    LT_H  = 3'd3,
    LT_HU = 3'd4
  } ldtype_t;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REGA_W = 5;

  // Sign-extend a byte to a full word.
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // Sign-extend a halfword to a full word.
  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/halfword from a
// little-endian word, extends it, and flags naturally misaligned accesses.
// Unknown load types behave as full-word loads.
module load_align
  import mips_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ldtype,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension by load type.
  always_comb begin
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = rdata[{addr_lo[1], 4'b0000} +: 16];
    data       = rdata;
    misaligned = 1'b0;
    case (ldtype)
      LT_B: begin
        data       = sext8(byte_sel);
        misaligned = 1'b0;
      end
      LT_BU: begin
        data       = {24'd0, byte_sel};
        misaligned = 1'b0;
      end
      LT_H: begin
        data       = sext16(half_sel);
        misaligned = addr_lo[0];
      end
      LT_HU: begin
        data       = {16'd0, half_sel};
        misaligned = addr_lo[0];
      end
      LT_W: begin
        data       = rdata;
        misaligned = (addr_lo != 2'd0);
      end
      default: begin
        data       = rdata;
        misaligned = (addr_lo != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, selects the writeback value,
// drives the register-file write port and counts retired instructions.
// Flush beats stall; writes to r0 and misaligned loads never assert we3.
module mem_wb_stage
  import mips_wb_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_valid,
  input  logic                m_regwrite,
  input  logic                m_memtoreg,
  input  logic [2:0]          m_ldtype,
  input  logic [1:0]          m_addr_lo,
  input  logic [4:0]          m_wa,
  input  logic [31:0]         m_aluout,
  input  logic [31:0]         m_rdata,
  input  logic                stall_w,
  input  logic                flush_w,
  output logic                we3,
  output logic [4:0]          wa3,
  output logic [31:0]         wd3,
  output logic                w_adel,
  output logic [1:0]          w_badaddr_lo,
  output logic [RETIRE_W-1:0] retired
);

  logic [31:0] load_data;
  logic        load_misaligned;
  logic        adel;
  logic        nxt_we;
  logic [31:0] nxt_wd;
  logic        retire_inc;
  logic        load_cycle;

  load_align u_load_align (
    .rdata      (m_rdata),
    .addr_lo    (m_addr_lo),
    .ldtype     (m_ldtype),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  // Next-value decode for a normal (non-stalled, non-flushed) cycle.
  always_comb begin
    adel       = 1'b0;
    nxt_we     = 1'b0;
    nxt_wd     = m_aluout;
    retire_inc = 1'b0;
    load_cycle = ~stall_w & ~flush_w;
    if (m_valid & m_memtoreg) begin
      adel = load_misaligned;
    end else begin
      adel = 1'b0;
    end
    if (m_memtoreg) begin
      nxt_wd = load_data;
    end else begin
      nxt_wd = m_aluout;
    end
    nxt_we     = m_valid & m_regwrite & (m_wa != 5'd0) & ~adel;
    retire_inc = load_cycle & m_valid & ~adel;
  end

  // Write-port and exception-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3          <= 1'b0;
      wa3          <= 5'd0;
      wd3          <= 32'd0;
      w_adel       <= 1'b0;
      w_badaddr_lo <= 2'd0;
    end else if (flush_w) begin
      we3    <= 1'b0;
      wa3    <= 5'd0;
      wd3    <= 32'd0;
      w_adel <= 1'b0;
    end else if (stall_w) begin
      w_adel <= 1'b0;
    end else begin
      we3          <= nxt_we;
      wa3          <= m_wa;
      wd3          <= nxt_wd;
      w_adel       <= m_valid & adel;
      w_badaddr_lo <= m_addr_lo;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= {RETIRE_W{1'b0}};
    end else if (retire_inc) begin
      retired <= retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retired <= retired;
    end
  end

endmodule
